// File: rtl/demux_pkg.sv
// demux_pkg: shared types and helpers for the stream demultiplexer.
// Holds the FSM state encoding and the select-width helper.
package demux_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOCK = 2'd1,
        DROP = 2'd2
    } state_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry holding register for a single output channel.
// A load in the same cycle as a drain keeps the slot full with the new beat.
module demux_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             drain_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             full,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last
);

    logic             r_full;
    logic [WIDTH-1:0] r_data;
    logic             r_last;

    // fill on load, empty on drain, load wins over drain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_data <= '0;
            r_last <= 1'b0;
        end else if (load) begin
            r_full <= 1'b1;
            r_data <= in_data;
            r_last <= in_last;
        end else if (drain_ready) begin
            r_full <= 1'b0;
        end
    end

    assign full     = r_full;
    assign out_data = r_data;
    assign out_last = r_last;

endmodule

// File: rtl/demux_stream.sv
// demux_stream: registered 1:N stream demultiplexer with optional
// per-packet route locking and dropping of out-of-range selects.
module demux_stream
    import demux_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = clog2_min1(CHANNELS),
    parameter bit PKT_MODE = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_last,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]       out_last,
    output logic                      sel_err
);

    state_t            r_state;
    logic [SEL_W-1:0]  r_lock;
    logic              r_sel_err;

    logic              w_sel_ok;
    logic [SEL_W-1:0]  w_tgt;
    logic              w_tgt_ok;
    logic [CHANNELS-1:0] w_hit;
    logic [CHANNELS-1:0] w_full;
    logic [CHANNELS-1:0] w_space;
    logic [CHANNELS-1:0] w_load;
    logic              w_acc;

    assign w_sel_ok = int'(in_sel) < CHANNELS;
    assign w_tgt    = (r_state == LOCK) ? r_lock : in_sel;
    assign w_tgt_ok = (r_state == LOCK) ||
                      ((r_state == IDLE) && w_sel_ok);

    // one-hot decode of the routing target
    always_comb begin
        w_hit = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            w_hit[k] = w_tgt_ok && (int'(w_tgt) == k);
        end
    end

    assign w_space  = ~w_full | out_ready;
    assign in_ready = ~rst & (w_tgt_ok ? |(w_hit & w_space) : 1'b1);
    assign w_acc    = in_valid & in_ready;
    assign w_load   = w_hit & {CHANNELS{w_acc}};

    // route-lock FSM and registered drop indication
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_lock    <= '0;
            r_sel_err <= 1'b0;
        end else begin
            r_sel_err <= 1'b0;
            if (w_acc) begin
                unique case (r_state)
                    IDLE: begin
                        if (!w_sel_ok) begin
                            r_sel_err <= 1'b1;
                            if (PKT_MODE && !in_last)
                                r_state <= DROP;
                        end else if (PKT_MODE && !in_last) begin
                            r_state <= LOCK;
                            r_lock  <= in_sel;
                        end
                    end
                    LOCK: if (in_last) r_state <= IDLE;
                    DROP: if (in_last) r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign sel_err = r_sel_err;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_slot
        demux_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk        (clk),
            .rst        (rst),
            .load       (w_load[k]),
            .drain_ready(out_ready[k]),
            .in_data    (in_data),
            .in_last    (in_last),
            .full       (w_full[k]),
            .out_data   (out_data[k*WIDTH +: WIDTH]),
            .out_last   (out_last[k])
        );
    end

    assign out_valid = w_full;

endmodule

// File: tb/tb_demux_stream.sv
// tb_demux_stream: directed scoreboard bench for demux_stream.
// Three instances cover beat mode, packet mode, and a 3-channel build.
module tb_demux_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_last;
    logic [3:0]  out_ready;
    logic        v0, v1, v2;

    logic        rdy0, rdy1, rdy2;
    logic [3:0]  ov0, ov1, ol0, ol1;
    logic [2:0]  ov2, ol2;
    logic [31:0] od0, od1;
    logic [23:0] od2;
    logic        err0, err1, err2;

    typedef struct {
        int       dut;
        int       ch;
        logic [7:0] d;
        logic     l;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    demux_stream #(.WIDTH(8), .CHANNELS(4), .PKT_MODE(1'b0)) u0 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_ready(rdy0),
        .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
        .out_last(ol0), .sel_err(err0)
    );

    demux_stream #(.WIDTH(8), .CHANNELS(4), .PKT_MODE(1'b1)) u1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1),
        .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
        .out_last(ol1), .sel_err(err1)
    );

    demux_stream #(.WIDTH(8), .CHANNELS(3), .PKT_MODE(1'b1)) u2 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_ready(rdy2),
        .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
        .out_valid(ov2), .out_ready(out_ready[2:0]), .out_data(od2),
        .out_last(ol2), .sel_err(err2)
    );

    function automatic logic get_rdy(int d);
        case (d)
            0: return rdy0;
            1: return rdy1;
            default: return rdy2;
        endcase
    endfunction

    function automatic logic get_v(int d, int c);
        case (d)
            0: return ov0[c];
            1: return ov1[c];
            default: return (c < 3) ? ov2[c] : 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] get_d(int d, int c);
        case (d)
            0: return od0[c*8 +: 8];
            1: return od1[c*8 +: 8];
            default: return (c < 3) ? od2[c*8 +: 8] : 8'h00;
        endcase
    endfunction

    function automatic logic get_l(int d, int c);
        case (d)
            0: return ol0[c];
            1: return ol1[c];
            default: return (c < 3) ? ol2[c] : 1'b0;
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(int d, int sel, logic [7:0] data, logic last);
        in_sel  = sel[1:0];
        in_data = data;
        in_last = last;
        v0 = (d == 0);
        v1 = (d == 1);
        v2 = (d == 2);
    endtask

    task automatic idle();
        v0 = 1'b0;
        v1 = 1'b0;
        v2 = 1'b0;
    endtask

    // one clock with the current drive; push expectation if accepted
    task automatic go(int d, int exp_ch, output logic acc);
        exp_t e;
        #1;
        acc = get_rdy(d);
        @(posedge clk);
        #1;
        if (acc && exp_ch >= 0) begin
            e.dut = d;
            e.ch  = exp_ch;
            e.d   = in_data;
            e.l   = in_last;
            sbq.push_back(e);
        end
        idle();
    endtask

    task automatic send(string tag, int d, int sel, logic [7:0] data,
                        logic last, int exp_ch);
        logic acc;
        drive(d, sel, data, last);
        go(d, exp_ch, acc);
        chk({tag, "_acc"}, 32'(acc), 32'd1);
    endtask

    task automatic pop_check(string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s observed=empty expected=entry", tag);
            return;
        end
        e = sbq.pop_front();
        chk({tag, "_v"}, 32'(get_v(e.dut, e.ch)), 32'd1);
        chk({tag, "_d"}, 32'(get_d(e.dut, e.ch)), 32'(e.d));
        chk({tag, "_l"}, 32'(get_l(e.dut, e.ch)), 32'(e.l));
    endtask

    initial begin
        logic acc;
        rst       = 1'b1;
        out_ready = 4'hF;
        in_data   = '0;
        in_sel    = '0;
        in_last   = 1'b0;
        idle();

        @(posedge clk);
        #1;
        chk("rst_rdy0", 32'(rdy0), 32'd0);
        chk("rst_ov0", 32'(ov0), 32'd0);
        chk("rst_od0", od0, 32'd0);
        chk("rst_ov1", 32'(ov1), 32'd0);
        chk("rst_err1", 32'(err1), 32'd0);
        rst = 1'b0;

        for (int k = 0; k < 4; k++) begin
            send("sweep", 0, k, 8'hA0 + 8'(k), 1'b0, k);
            pop_check("sweep");
        end

        out_ready[2] = 1'b0;
        send("bp1", 0, 2, 8'h11, 1'b0, 2);
        pop_check("bp1");
        drive(0, 2, 8'h22, 1'b0);
        #1;
        chk("bp_rdy_lo", 32'(rdy0), 32'd0);
        go(0, 2, acc);
        chk("bp_stall", 32'(acc), 32'd0);
        chk("bp_hold", 32'(get_d(0, 2)), 32'h11);
        drive(0, 2, 8'h22, 1'b0);
        out_ready[2] = 1'b1;
        #1;
        chk("bp_rdy_hi", 32'(rdy0), 32'd1);
        go(0, 2, acc);
        chk("bp2_acc", 32'(acc), 32'd1);
        pop_check("bp2");

        out_ready[1] = 1'b0;
        send("ind1", 0, 1, 8'h33, 1'b0, 1);
        pop_check("ind1");
        send("ind3", 0, 3, 8'h5A, 1'b0, 3);
        pop_check("ind3");
        chk("ind_ch1_v", 32'(get_v(0, 1)), 32'd1);
        chk("ind_ch1_d", 32'(get_d(0, 1)), 32'h33);
        out_ready[1] = 1'b1;
        @(posedge clk);
        #1;

        send("pk1", 1, 1, 8'h01, 1'b0, 1);
        pop_check("pk1");
        send("pk2", 1, 0, 8'h02, 1'b0, 1);
        pop_check("pk2");
        send("pk3", 1, 3, 8'h03, 1'b1, 1);
        pop_check("pk3");
        send("pk_idle", 1, 3, 8'h44, 1'b1, 3);
        pop_check("pk_idle");
        chk("pk_err", 32'(err1), 32'd0);

        send("drop1", 2, 3, 8'h70, 1'b0, -1);
        chk("drop1_err", 32'(err2), 32'd1);
        chk("drop1_ov", 32'(ov2), 32'd0);
        send("drop2", 2, 0, 8'h71, 1'b0, -1);
        chk("drop2_err", 32'(err2), 32'd0);
        chk("drop2_ov", 32'(ov2), 32'd0);
        send("drop3", 2, 1, 8'h72, 1'b1, -1);
        chk("drop3_err", 32'(err2), 32'd0);
        chk("drop3_ov", 32'(ov2), 32'd0);
        send("drop_after", 2, 2, 8'h73, 1'b1, 2);
        pop_check("drop_after");

        out_ready[0] = 1'b0;
        send("mr1", 1, 0, 8'h81, 1'b0, 0);
        pop_check("mr1");
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mr_ov", 32'(ov1), 32'd0);
        chk("mr_err", 32'(err1), 32'd0);
        send("mr2", 1, 2, 8'h92, 1'b1, 2);
        pop_check("mr2");
        out_ready[0] = 1'b1;

        chk("sb_empty", 32'(sbq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/demux_stream.md
Name: demux_stream

Overview:
- Registered, parametrised 1:N stream demultiplexer; the sequential successor of the lab 1:4 combinational demux.
- Routes each input beat to one of CHANNELS outputs selected by in_sel.
- Uses a valid/ready handshake with a one-entry holding register per channel.
- Optional packet mode locks the selected channel from the first beat to the last beat of a packet.

Parameters:
- WIDTH, 8: data bits per beat.
- CHANNELS, 4: number of output channels (2..16; need not be a power of 2).
- SEL_W, $clog2(CHANNELS) (min 1): select width.
- PKT_MODE, 1: 1 = lock route per packet using in_last; 0 = route every beat by its own in_sel.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: input beat valid.
- in_ready, output, 1: block can accept the beat this cycle.
- in_data, input, WIDTH: input payload.
- in_sel, input, SEL_W: destination channel.
- in_last, input, 1: last beat of packet (ignored when PKT_MODE=0).
- out_valid, output, CHANNELS: per-channel valid.
- out_ready, input, CHANNELS: per-channel ready from consumers.
- out_data, output, CHANNELS*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
- out_last, output, CHANNELS: per-channel last flag.
- sel_err, output, 1: one-cycle pulse when a beat is dropped because its select is out of range.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_data=0, out_last=0, sel_err=0, FSM=IDLE, locked channel=0.
  - in_ready=0 during the reset cycle.
  - Reset mid-packet discards all held beats and the lock.
- Transfers: an input transfer occurs when in_valid & in_ready; a channel k transfer occurs when out_valid[k] & out_ready[k].
- Routing target (tgt):
  - IDLE: tgt=in_sel.
  - LOCK: tgt=locked channel; in_sel is ignored.
  - DROP: no target.
- in_ready (combinational, no dependency on in_valid):
  - LOCK, or IDLE with in_sel < CHANNELS: in_ready = ~out_valid[tgt] | out_ready[tgt], i.e. back-to-back throughput is allowed.
  - IDLE with in_sel >= CHANNELS, or DROP: in_ready=1.
- Latency: a beat accepted at edge n appears on out_valid/out_data/out_last of channel tgt after edge n. Registered outputs; no combinational path from in_data to out_data.
- Holding register: out_valid[k] stays 1 with stable data until the channel-k transfer. Simultaneous drain and fill of the same channel loads the new beat and keeps out_valid=1.
- Channels are independent: a stalled channel does not block beats to other channels in PKT_MODE=0 or in IDLE.
- FSM, PKT_MODE=1 (states IDLE, LOCK, DROP):
  - IDLE, accepted beat, valid sel, in_last=0 -> LOCK; latch sel.
  - IDLE, accepted beat, valid sel, in_last=1 -> stay IDLE (single-beat packet).
  - IDLE, accepted beat, invalid sel -> sel_err pulses; in_last=0 -> DROP, in_last=1 -> IDLE.
  - LOCK, accepted beat with in_last=1 -> IDLE.
  - DROP, accepted beat (discarded) with in_last=1 -> IDLE. sel_err pulses only on the first dropped beat.
- PKT_MODE=0:
  - FSM stays in IDLE.
  - Every accepted beat with an invalid sel is dropped and pulses sel_err.
  - out_last copies in_last.
- sel_err is registered: it is high on the cycle after the dropping acceptance, for exactly one cycle per event.
- Beats are never reordered within a channel. No beat is lost except those with an invalid sel.

Decomposition:
- Package demux_pkg:
  - FSM state enum: IDLE=2'd0, LOCK=2'd1, DROP=2'd2.
  - Function clog2_min1 for SEL_W.
- Sub-module demux_slot (WIDTH parameter):
  - One-entry valid/data/last holding register per channel, with ports load, drain_ready, full.
  - Instantiated CHANNELS times with a generate loop.
- Top level holds the FSM, the select decode and the in_ready mux.

Test Plan:
- Reset then sweep: PKT_MODE=0, all out_ready=1; send data 8'hA0..8'hA3 with sel=0..3, one per cycle -> each channel k shows 8'hA0+k one cycle after acceptance; in_ready stays 1 throughout.
- Backpressure: out_ready[2]=0; send 8'h11 then 8'h22 both to sel=2 -> out_data ch2=8'h11 holds and in_ready=0 on the second beat. Raise out_ready[2] -> 8'h22 follows on the next cycle with no loss.
- Independence: ch1 stalled holding a beat; send sel=3 data 8'h5A -> accepted immediately, ch3 valid the next cycle.
- Packet lock: PKT_MODE=1; 3-beat packet 8'h01,8'h02,8'h03 with first in_sel=1, later in_sel=0,3, in_last only on 8'h03 -> all three beats appear on ch1, out_last[1]=1 only with 8'h03, FSM returns to IDLE.
- Invalid select: CHANNELS=3; in_sel=3 with in_last=0, then two more beats, the last with in_last=1 -> all dropped, in_ready=1, sel_err high for one cycle only, no out_valid asserted.
- Mid-packet reset: assert rst while in LOCK with ch0 holding a beat -> next cycle out_valid=0, sel_err=0. New packet with sel=2 is routed to ch2.
